matmul_compute: RTL

Compute stage directly downstream of the input memory block. Once matrices_loaded is high it reads A (MxK) and B (KxN) through the single-cycle-latency read ports, multiplies them with one signed MAC, and streams C = A*B row-major on an AXI-Stream master. After the last C element is accepted, it pulses compute_finished so the input stage can reload.

---
 rtl/matmul_compute.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/matmul_compute.sv
// matmul_compute: streams C = A*B (A is MxK, B is KxN, both row-major) on an
// AXI-Stream master using a single signed MAC fed from one-cycle-latency
// read ports. It pulses compute_finished once the last C element is accepted.
// Optional build macro MATMUL_RELU_EN clamps negative outputs to zero.
module matmul_compute #(
   parameter int INW  = 12,
   parameter int OUTW = 32,
   parameter int M    = 7,
   parameter int N    = 9,
   parameter int MAXK = 8
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              matrices_loaded,
   input  logic [$clog2(MAXK+1)-1:0]         K,
   output logic [$clog2(M*MAXK)-1:0]         A_read_addr,
   input  logic signed [INW-1:0]             A_data,
   output logic [$clog2(MAXK*N)-1:0]         B_read_addr,
   input  logic signed [INW-1:0]             B_data,
   output logic                              compute_finished,
   output logic signed [OUTW-1:0]            AXIS_TDATA,
   output logic                              AXIS_TVALID,
   input  logic                              AXIS_TREADY
);

   localparam int KW = $clog2(MAXK+1);
   localparam int AW = $clog2(M*MAXK);
   localparam int BW = $clog2(MAXK*N);
   localparam int MW = (M > 1) ? $clog2(M) : 1;
   localparam int NW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_OUTPUT,
      S_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [MW-1:0]          m_q, m_d;
   logic [NW-1:0]          n_q, n_d;
   logic [KW-1:0]          k_q, k_d;
   logic [KW-1:0]          kreg_q, kreg_d;
   logic signed [OUTW-1:0] acc_q, acc_d;
   logic signed [OUTW-1:0] tdata_q, tdata_d;
   logic                   tvalid_q, tvalid_d;
   logic                   armed_q, armed_d;
   logic                   mac_v_q, mac_v_d;   // read data is arriving this cycle
   logic                   first_q, first_d;   // arriving data is the k=0 term

   logic signed [2*INW-1:0] prod;
   logic signed [OUTW-1:0]  prod_ext;
   logic                    more_elems;

   // Value presented on the stream; the accumulator itself is never clamped.
   function automatic logic signed [OUTW-1:0] out_val(input logic signed [OUTW-1:0] a);
`ifdef MATMUL_RELU_EN
      return a[OUTW-1] ? '0 : a;
`else
      return a;
`endif
   endfunction

   assign prod     = A_data * B_data;
   assign prod_ext = OUTW'(prod);

   // Addresses follow the counters; products and sums are taken modulo the port width.
   assign A_read_addr = AW'(m_q) * AW'(kreg_q) + AW'(k_q);
   assign B_read_addr = BW'(k_q) * BW'(N) + BW'(n_q);

   assign AXIS_TDATA       = tdata_q;
   assign AXIS_TVALID      = tvalid_q;
   assign compute_finished = (state_q == S_DONE);

   // Next-state logic for the sequencer and the MAC stage that trails it by one cycle.
   always_comb begin
      state_d    = state_q;
      m_d        = m_q;
      n_d        = n_q;
      k_d        = k_q;
      kreg_d     = kreg_q;
      acc_d      = acc_q;
      tdata_d    = tdata_q;
      tvalid_d   = tvalid_q;
      armed_d    = armed_q;
      mac_v_d    = 1'b0;
      first_d    = 1'b0;
      more_elems = 1'b0;

      if (mac_v_q) begin
         acc_d = first_q ? prod_ext : acc_q + prod_ext;
      end

      // Only a low sample of matrices_loaded re-arms the block.
      if (!matrices_loaded) begin
         armed_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (matrices_loaded && armed_q) begin
               kreg_d  = K;
               m_d     = '0;
               n_d     = '0;
               k_d     = '0;
               armed_d = 1'b0;
               if (K == '0) begin
                  acc_d    = '0;
                  tdata_d  = '0;
                  tvalid_d = 1'b1;
                  state_d  = S_OUTPUT;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            mac_v_d = 1'b1;
            first_d = (k_q == '0);
            if (k_q == kreg_q - KW'(1)) begin
               state_d = S_DRAIN;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         S_DRAIN: begin
            // acc_d already includes the final product arriving this cycle.
            tdata_d  = out_val(acc_d);
            tvalid_d = 1'b1;
            state_d  = S_OUTPUT;
         end
         S_OUTPUT: begin
            if (AXIS_TREADY) begin
               tvalid_d = 1'b0;
               k_d      = '0;
               if (n_q < NW'(N-1)) begin
                  n_d        = n_q + NW'(1);
                  more_elems = 1'b1;
               end else if (m_q < MW'(M-1)) begin
                  n_d        = '0;
                  m_d        = m_q + MW'(1);
                  more_elems = 1'b1;
               end else begin
                  state_d = S_DONE;
               end
               if (more_elems) begin
                  if (kreg_q == '0) begin
                     // Empty inner dimension: every element is zero, no reads.
                     tvalid_d = 1'b1;
                     tdata_d  = '0;
                  end else begin
                     state_d = S_ISSUE;
                  end
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         m_q      <= '0;
         n_q      <= '0;
         k_q      <= '0;
         kreg_q   <= '0;
         acc_q    <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         armed_q  <= 1'b1;
         mac_v_q  <= 1'b0;
         first_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         m_q      <= m_d;
         n_q      <= n_d;
         k_q      <= k_d;
         kreg_q   <= kreg_d;
         acc_q    <= acc_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         armed_q  <= armed_d;
         mac_v_q  <= mac_v_d;
         first_q  <= first_d;
      end
   end

endmodule
